// File: rtl/conv_stream_feeder.sv
// conv_stream_feeder
//   On-chip IFM / weight source for the CONV_POOL engine. Both buffers are
//   loaded over a simple write port while the block is idle. A job replays
//   the whole IFM volume once per output channel and streams the weight set
//   once, each side answering its own read strobe with registered data one
//   cycle later.
//
//   Optional build macro: PAD_INSERT_EN
//     When defined, each IFM channel is streamed as a (IFM_SIZE+2*PAD)^2
//     plane whose border positions read as zero without consuming buffer
//     words. When undefined, the stream is the raw buffer and PAD is unused.
//
//   Read strobe semantics (both sides): a strobe sampled high on a rising
//   edge while the side is active is accepted; its word appears with the
//   matching valid for exactly the following cycle. There is no backpressure
//   toward the engine. A strobe on an idle or exhausted side returns
//   valid = 0 / data = 0 and sets the sticky err_rd flag. A strobe in the
//   same cycle as start is dropped silently.
module conv_stream_feeder #(
   parameter int IFM_WIDTH    = 16,
   parameter int WEIGHT_WIDTH = 16,
   parameter int IFM_SIZE     = 13,
   parameter int KERNEL_SIZE  = 3,
   parameter int PAD          = 1,
   parameter int CI           = 3,
   parameter int CO           = 16,
   parameter int LD_AW        = 18
) (
   input  logic                    clk1,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    ld_we,
   input  logic                    ld_sel,
   input  logic [LD_AW-1:0]        ld_addr,
   input  logic [15:0]             ld_data,
   input  logic                    ifm_read,
   output logic [IFM_WIDTH-1:0]    ifm,
   output logic                    ifm_valid,
   input  logic                    wgt_read,
   output logic [WEIGHT_WIDTH-1:0] wgt,
   output logic                    wgt_valid,
   output logic [15:0]             pass_cnt,
   output logic                    busy,
   output logic                    done,
   output logic                    err_rd,
   output logic                    err_ld
);

   // Buffer depths and pointer widths.
   localparam int NI   = CI * IFM_SIZE * IFM_SIZE;
   localparam int NW   = CO * CI * KERNEL_SIZE * KERNEL_SIZE;
   localparam int IP_W = (NI > 1) ? $clog2(NI) : 1;
   localparam int WP_W = (NW > 1) ? $clog2(NW) : 1;

   // Border width actually applied to the stream; zero without insertion.
`ifdef PAD_INSERT_EN
   localparam int PAD_EFF = PAD;
`else
   localparam int PAD_EFF = 0 * PAD;
`endif
   localparam int PS         = IFM_SIZE + 2 * PAD_EFF;
   localparam int STREAM_LEN = CI * PS * PS;

`ifdef PAD_INSERT_EN
   localparam int PS_W = (PS > 1) ? $clog2(PS) : 1;
   localparam int SP_W = (STREAM_LEN > 1) ? $clog2(STREAM_LEN) : 1;
`endif

   // Job-level FSM: RUN while either side still has words to serve, DONE for
   // the single completion cycle.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t state_q, state_d;

   // Buffers (no reset: contents must survive rst).
   logic [IFM_WIDTH-1:0]    ifm_mem [NI];
   logic [WEIGHT_WIDTH-1:0] wgt_mem [NW];

   // Datapath state.
   logic [IP_W-1:0]         ifm_ptr_q,   ifm_ptr_d;
   logic [WP_W-1:0]         wgt_ptr_q,   wgt_ptr_d;
   logic [15:0]             pass_cnt_q,  pass_cnt_d;
   logic                    ifm_act_q,   ifm_act_d;
   logic                    wgt_act_q,   wgt_act_d;
   logic [IFM_WIDTH-1:0]    ifm_q,       ifm_d;
   logic                    ifm_valid_q, ifm_valid_d;
   logic [WEIGHT_WIDTH-1:0] wgt_q,       wgt_d;
   logic                    wgt_valid_q, wgt_valid_d;
   logic                    err_rd_q,    err_rd_d;
   logic                    err_ld_q,    err_ld_d;
   logic                    pass_wrap;

`ifdef PAD_INSERT_EN
   // Position inside the padded plane and inside the whole padded stream.
   logic [PS_W-1:0]         row_q, row_d;
   logic [PS_W-1:0]         col_q, col_d;
   logic [SP_W-1:0]         pos_q, pos_d;
   logic                    border;

   assign border = (row_q <  PS_W'(PAD_EFF))            ||
                   (row_q >= PS_W'(IFM_SIZE + PAD_EFF)) ||
                   (col_q <  PS_W'(PAD_EFF))            ||
                   (col_q >= PS_W'(IFM_SIZE + PAD_EFF));
`endif

   // Load acceptance: idle only, and only for in-range addresses.
   logic ifm_ld_ok;
   logic wgt_ld_ok;

   assign ifm_ld_ok = ld_we && !busy && !ld_sel && (32'(ld_addr) < 32'(NI));
   assign wgt_ld_ok = ld_we && !busy &&  ld_sel && (32'(ld_addr) < 32'(NW));

   // Buffer write port.
   always_ff @(posedge clk1) begin
      if (ifm_ld_ok) begin
         ifm_mem[ld_addr[IP_W-1:0]] <= ld_data[IFM_WIDTH-1:0];
      end
      if (wgt_ld_ok) begin
         wgt_mem[ld_addr[WP_W-1:0]] <= ld_data[WEIGHT_WIDTH-1:0];
      end
   end

   // FSM state register.
   always_ff @(posedge clk1) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state: start always (re)enters RUN; RUN ends once both sides
   // will be exhausted after this edge.
   always_comb begin
      state_d = state_q;
      if (start) begin
         state_d = ST_RUN;
      end else begin
         case (state_q)
            ST_RUN:  if (!ifm_act_d && !wgt_act_d) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = state_q;
         endcase
      end
   end

   // FSM outputs: busy while running, done for the single DONE cycle.
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state_q)
         ST_RUN:  busy = 1'b1;
         ST_DONE: done = 1'b1;
         default: ;
      endcase
   end

   // Datapath next state: strobe service, pointer and pass stepping, errors.
   always_comb begin
      ifm_d       = '0;
      ifm_valid_d = 1'b0;
      wgt_d       = '0;
      wgt_valid_d = 1'b0;
      ifm_ptr_d   = ifm_ptr_q;
      wgt_ptr_d   = wgt_ptr_q;
      pass_cnt_d  = pass_cnt_q;
      ifm_act_d   = ifm_act_q;
      wgt_act_d   = wgt_act_q;
      err_rd_d    = err_rd_q;
      err_ld_d    = err_ld_q;
      pass_wrap   = 1'b0;
`ifdef PAD_INSERT_EN
      row_d       = row_q;
      col_d       = col_q;
      pos_d       = pos_q;
`endif
      if (start) begin
         // Fresh job: same-cycle strobes and loads are not serviced.
         ifm_ptr_d  = '0;
         wgt_ptr_d  = '0;
         pass_cnt_d = '0;
         ifm_act_d  = 1'b1;
         wgt_act_d  = 1'b1;
         err_rd_d   = 1'b0;
         err_ld_d   = 1'b0;
`ifdef PAD_INSERT_EN
         row_d      = '0;
         col_d      = '0;
         pos_d      = '0;
`endif
      end else begin
         // IFM side.
         if (ifm_read) begin
            if (ifm_act_q) begin
               ifm_valid_d = 1'b1;
`ifdef PAD_INSERT_EN
               // Border positions read as zero and hold the buffer pointer.
               if (!border) begin
                  ifm_d     = ifm_mem[ifm_ptr_q];
                  ifm_ptr_d = ifm_ptr_q + IP_W'(1);
               end
               if (col_q == PS_W'(PS - 1)) begin
                  col_d = '0;
                  row_d = (row_q == PS_W'(PS - 1)) ? '0 : row_q + PS_W'(1);
               end else begin
                  col_d = col_q + PS_W'(1);
               end
               if (pos_q == SP_W'(STREAM_LEN - 1)) begin
                  pos_d     = '0;
                  pass_wrap = 1'b1;
               end else begin
                  pos_d = pos_q + SP_W'(1);
               end
`else
               ifm_d = ifm_mem[ifm_ptr_q];
               if (ifm_ptr_q == IP_W'(STREAM_LEN - 1)) begin
                  pass_wrap = 1'b1;
               end else begin
                  ifm_ptr_d = ifm_ptr_q + IP_W'(1);
               end
`endif
               // End of one full volume: rewind and count the replay.
               if (pass_wrap) begin
                  ifm_ptr_d  = '0;
                  pass_cnt_d = pass_cnt_q + 16'd1;
                  if (pass_cnt_q + 16'd1 == 16'(CO)) begin
                     ifm_act_d = 1'b0;
                  end
               end
            end else begin
               err_rd_d = 1'b1;
            end
         end
         // Weight side: a single pass over the weight buffer.
         if (wgt_read) begin
            if (wgt_act_q) begin
               wgt_d       = wgt_mem[wgt_ptr_q];
               wgt_valid_d = 1'b1;
               if (wgt_ptr_q == WP_W'(NW - 1)) begin
                  wgt_act_d = 1'b0;
               end else begin
                  wgt_ptr_d = wgt_ptr_q + WP_W'(1);
               end
            end else begin
               err_rd_d = 1'b1;
            end
         end
         // Loads during a job are refused and flagged.
         if (ld_we && busy) begin
            err_ld_d = 1'b1;
         end
      end
   end

   // Datapath registers.
   always_ff @(posedge clk1) begin
      if (rst) begin
         ifm_ptr_q   <= '0;
         wgt_ptr_q   <= '0;
         pass_cnt_q  <= '0;
         ifm_act_q   <= 1'b0;
         wgt_act_q   <= 1'b0;
         ifm_q       <= '0;
         ifm_valid_q <= 1'b0;
         wgt_q       <= '0;
         wgt_valid_q <= 1'b0;
         err_rd_q    <= 1'b0;
         err_ld_q    <= 1'b0;
`ifdef PAD_INSERT_EN
         row_q       <= '0;
         col_q       <= '0;
         pos_q       <= '0;
`endif
      end else begin
         ifm_ptr_q   <= ifm_ptr_d;
         wgt_ptr_q   <= wgt_ptr_d;
         pass_cnt_q  <= pass_cnt_d;
         ifm_act_q   <= ifm_act_d;
         wgt_act_q   <= wgt_act_d;
         ifm_q       <= ifm_d;
         ifm_valid_q <= ifm_valid_d;
         wgt_q       <= wgt_d;
         wgt_valid_q <= wgt_valid_d;
         err_rd_q    <= err_rd_d;
         err_ld_q    <= err_ld_d;
`ifdef PAD_INSERT_EN
         row_q       <= row_d;
         col_q       <= col_d;
         pos_q       <= pos_d;
`endif
      end
   end

   assign ifm       = ifm_q;
   assign ifm_valid = ifm_valid_q;
   assign wgt       = wgt_q;
   assign wgt_valid = wgt_valid_q;
   assign pass_cnt  = pass_cnt_q;
   assign err_rd    = err_rd_q;
   assign err_ld    = err_ld_q;

endmodule

// File: tb/tb_conv_stream_feeder.sv
// tb_conv_stream_feeder
//   Directed bench for conv_stream_feeder with IFM_SIZE=4, CI=2, CO=3,
//   KERNEL_SIZE=3 (NI=32, NW=54). Buffers hold ifm[i]=i+1, wgt[j]=j+100.
//   Build with PAD_INSERT_EN defined to exercise the zero-border stream.
module tb_conv_stream_feeder;

   localparam int IFM_SIZE = 4;
   localparam int CI       = 2;
   localparam int CO       = 3;
   localparam int KS       = 3;
   localparam int NI       = CI * IFM_SIZE * IFM_SIZE;
   localparam int NW       = CO * CI * KS * KS;
`ifdef PAD_INSERT_EN
   localparam int STREAM   = 72;
`else
   localparam int STREAM   = 32;
`endif
   localparam int N_IFM    = CO * STREAM;
   localparam int LAST_C   = (N_IFM - 1 > 2 * (NW - 1)) ? N_IFM - 1 : 2 * (NW - 1);

   // Clock / reset and DUT signals.
   logic        clk1 = 1'b0;
   logic        rst;
   logic        start;
   logic        ld_we;
   logic        ld_sel;
   logic [17:0] ld_addr;
   logic [15:0] ld_data;
   logic        ifm_read;
   logic [15:0] ifm;
   logic        ifm_valid;
   logic        wgt_read;
   logic [15:0] wgt;
   logic        wgt_valid;
   logic [15:0] pass_cnt;
   logic        busy;
   logic        done;
   logic        err_rd;
   logic        err_ld;

   always #5 clk1 = ~clk1;

   conv_stream_feeder #(
      .IFM_WIDTH    (16),
      .WEIGHT_WIDTH (16),
      .IFM_SIZE     (IFM_SIZE),
      .KERNEL_SIZE  (KS),
      .PAD          (1),
      .CI           (CI),
      .CO           (CO),
      .LD_AW        (18)
   ) dut (
      .clk1      (clk1),
      .rst       (rst),
      .start     (start),
      .ld_we     (ld_we),
      .ld_sel    (ld_sel),
      .ld_addr   (ld_addr),
      .ld_data   (ld_data),
      .ifm_read  (ifm_read),
      .ifm       (ifm),
      .ifm_valid (ifm_valid),
      .wgt_read  (wgt_read),
      .wgt       (wgt),
      .wgt_valid (wgt_valid),
      .pass_cnt  (pass_cnt),
      .busy      (busy),
      .done      (done),
      .err_rd    (err_rd),
      .err_ld    (err_ld)
   );

   // Scoreboard state.
   logic [15:0] ifm_exp_q[$];
   logic [15:0] wgt_exp_q[$];
   int          checks = 0;
   int          errors = 0;
   logic        mon_en = 1'b0;

`ifdef PAD_INSERT_EN
   // Hand-derived first 12 words of the padded stream (6x6 plane).
   logic [15:0] pad_tbl [12];
`endif

   // Expected IFM word at stream index k of a job.
   function automatic logic [15:0] ifm_model(int k);
      int p;
      p = k % STREAM;
`ifdef PAD_INSERT_EN
      begin
         int ch;
         int r;
         int cc;
         ch = p / 36;
         r  = (p % 36) / 6;
         cc = p % 6;
         if (r < 1 || r > 4 || cc < 1 || cc > 4) return 16'd0;
         return 16'(ch * 16 + (r - 1) * 4 + (cc - 1) + 1);
      end
`else
      return 16'(p + 1);
`endif
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk1);
      #1;
   endtask

   task automatic load(input logic sel, input int addr, input int data);
      ld_we   = 1'b1;
      ld_sel  = sel;
      ld_addr = 18'(addr);
      ld_data = 16'(data);
      step();
      ld_we   = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   // Monitor: pops an expected word whenever a valid is presented.
   always @(negedge clk1) begin
      if (mon_en) begin
         if (ifm_valid) begin
            checks++;
            if (ifm_exp_q.size() == 0) begin
               errors++;
               $display("FAIL ifm_unexpected actual=%0d expected=none", ifm);
            end else begin
               logic [15:0] e;
               e = ifm_exp_q.pop_front();
               if (ifm !== e) begin
                  errors++;
                  $display("FAIL ifm_data actual=%0d expected=%0d", ifm, e);
               end
            end
         end else begin
            checks++;
            if (ifm !== 16'd0) begin
               errors++;
               $display("FAIL ifm_idle_zero actual=%0d expected=0", ifm);
            end
         end
         if (wgt_valid) begin
            checks++;
            if (wgt_exp_q.size() == 0) begin
               errors++;
               $display("FAIL wgt_unexpected actual=%0d expected=none", wgt);
            end else begin
               logic [15:0] e;
               e = wgt_exp_q.pop_front();
               if (wgt !== e) begin
                  errors++;
                  $display("FAIL wgt_data actual=%0d expected=%0d", wgt, e);
               end
            end
         end else begin
            checks++;
            if (wgt !== 16'd0) begin
               errors++;
               $display("FAIL wgt_idle_zero actual=%0d expected=0", wgt);
            end
         end
      end
   end

   task automatic check_all_zero(input string tag);
      check({tag, "_ifm"},       32'(ifm),       0);
      check({tag, "_ifm_valid"}, 32'(ifm_valid), 0);
      check({tag, "_wgt"},       32'(wgt),       0);
      check({tag, "_wgt_valid"}, 32'(wgt_valid), 0);
      check({tag, "_pass_cnt"},  32'(pass_cnt),  0);
      check({tag, "_busy"},      32'(busy),      0);
      check({tag, "_done"},      32'(done),      0);
      check({tag, "_err_rd"},    32'(err_rd),    0);
      check({tag, "_err_ld"},    32'(err_ld),    0);
   endtask

   // Stimulus driver.
   initial begin
`ifdef PAD_INSERT_EN
      pad_tbl = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0,
                  16'd0, 16'd1, 16'd2, 16'd3, 16'd4, 16'd0};
`endif
      rst      = 1'b1;
      start    = 1'b0;
      ld_we    = 1'b0;
      ld_sel   = 1'b0;
      ld_addr  = '0;
      ld_data  = '0;
      ifm_read = 1'b0;
      wgt_read = 1'b0;
      repeat (3) step();
      rst = 1'b0;
      check_all_zero("rst");
      mon_en = 1'b1;

      // Preload; out-of-range writes must be dropped without aliasing.
      for (int i = 0; i < NI; i++) load(1'b0, i, i + 1);
      for (int j = 0; j < NW; j++) load(1'b1, j, j + 100);
      load(1'b0, NI, 777);
      load(1'b1, NW, 555);
      check("load_idle_err_ld", 32'(err_ld), 0);

      // Test 1: reset in the middle of a stream.
      pulse_start();
      ifm_read = 1'b1;
      for (int k = 0; k < 5; k++) begin
         ifm_exp_q.push_back(ifm_model(k));
         step();
      end
      rst = 1'b1;
      repeat (2) step();
      rst      = 1'b0;
      ifm_read = 1'b0;
      check_all_zero("t1");
      check("t1_drain", 32'(ifm_exp_q.size()), 0);
      for (int k = 0; k < 3; k++) begin
         step();
         check("t1_no_done", 32'(done), 0);
      end

      // Tests 2/3/6: full IFM replay interleaved with the weight stream.
      pulse_start();
      for (int c = 0; c <= LAST_C + 4; c++) begin
         ifm_read = (c < N_IFM + 1);
         wgt_read = (c < 2 * NW) && (c % 2 == 0);
         if (ifm_read && c < N_IFM) begin
`ifdef PAD_INSERT_EN
            if (c < 12) ifm_exp_q.push_back(pad_tbl[c]);
            else        ifm_exp_q.push_back(ifm_model(c));
`else
            ifm_exp_q.push_back(ifm_model(c));
`endif
         end
         if (wgt_read) wgt_exp_q.push_back(16'(100 + c / 2));
         step();
         check("t2_pass_cnt", 32'(pass_cnt),
               32'(((c + 1 < N_IFM) ? c + 1 : N_IFM) / STREAM));
         check("t3_done", 32'(done), 32'(c == LAST_C));
         check("t3_busy", 32'(busy), 32'(c < LAST_C));
         if (c == N_IFM - 1) check("t2_err_before", 32'(err_rd), 0);
         if (c == N_IFM) begin
            check("t2_extra_valid", 32'(ifm_valid), 0);
            check("t2_extra_err",   32'(err_rd),    1);
         end
      end
      ifm_read = 1'b0;
      wgt_read = 1'b0;
      step();
      check("t2_drain", 32'(ifm_exp_q.size()), 0);
      check("t3_drain", 32'(wgt_exp_q.size()), 0);
      check("t3_err_sticky", 32'(err_rd), 1);

      // Tests 4/5: load guard, then restart with a colliding strobe.
      pulse_start();
      ifm_read = 1'b1;
      for (int k = 0; k < 10; k++) begin
         ifm_exp_q.push_back(ifm_model(k));
         step();
      end
      ifm_read = 1'b0;
      ld_we    = 1'b1;
      ld_sel   = 1'b0;
      ld_addr  = 18'd0;
      ld_data  = 16'd99;
      step();
      ld_we = 1'b0;
      check("t5_err_ld", 32'(err_ld), 1);
      check("t5_busy",   32'(busy),   1);
      start    = 1'b1;
      ifm_read = 1'b1;
      step();
      start = 1'b0;
      check("t4_start_valid", 32'(ifm_valid), 0);
      check("t4_pass_cnt",    32'(pass_cnt),  0);
      check("t4_err_ld",      32'(err_ld),    0);
      check("t4_err_rd",      32'(err_rd),    0);
      for (int k = 0; k < 8; k++) begin
         ifm_exp_q.push_back(ifm_model(k));
         step();
      end
      ifm_read = 1'b0;
      step();
      check("t4_drain", 32'(ifm_exp_q.size()), 0);
      check("t4_err_rd_end", 32'(err_rd), 0);

      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
      mon_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
